// File: rtl/vga_text_writer_pkg.sv
// Shared constants for the VGA text-buffer writer and related debug printers.
package vga_text_writer_pkg;

  localparam int unsigned COLS   = 80;
  localparam int unsigned ROWS   = 30;
  localparam int unsigned ADDR_W = 12;

  typedef enum logic [1:0] {
    CMD_HEX   = 2'b00,
    CMD_CHAR  = 2'b01,
    CMD_CLEAR = 2'b10,
    CMD_RSVD  = 2'b11
  } cmd_e;

  localparam logic [7:0] ASCII_0   = 8'h30;
  localparam logic [7:0] ASCII_A   = 8'h41;
  localparam logic [7:0] FILL_CHAR = 8'h20;

endpackage

// File: rtl/vga_text_writer_if.sv
// Print-command handshake plus text-buffer write port of the VGA text writer.
interface vga_text_writer_if #(
  parameter int unsigned ADDR_W = vga_text_writer_pkg::ADDR_W
);

  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_cmd;
  logic [4:0]        req_row;
  logic [6:0]        req_col;
  logic [31:0]       req_value;
  logic [2:0]        req_ndigits;
  logic              done;
  logic              err;
  logic              wen;
  logic [ADDR_W-1:0] w_addr;
  logic [7:0]        w_data;

  // Command issuer (debug / CPU-status logic).
  modport master (
    output req_valid, req_cmd, req_row, req_col, req_value, req_ndigits,
    input  req_ready, done, err, wen, w_addr, w_data
  );

  // The writer itself.
  modport slave (
    input  req_valid, req_cmd, req_row, req_col, req_value, req_ndigits,
    output req_ready, done, err, wen, w_addr, w_data
  );

endinterface

// File: rtl/hex_to_ascii.sv
// Combinational 4-bit nibble to upper-case ASCII hex digit.
module hex_to_ascii (
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);
  import vga_text_writer_pkg::*;

  // 0-9 map onto '0'.., 10-15 onto 'A'..
  always_comb begin
    if (nibble < 4'd10) ascii = ASCII_0 + {4'b0000, nibble};
    else                ascii = ASCII_A + {4'b0000, nibble} - 8'd10;
  end

endmodule

// File: rtl/vga_text_writer.sv
// Expands HEX / CHAR / CLEAR print commands into one text-buffer write per clock.
module vga_text_writer #(
  parameter int unsigned COLS      = vga_text_writer_pkg::COLS,
  parameter int unsigned ROWS      = vga_text_writer_pkg::ROWS,
  parameter int unsigned ADDR_W    = vga_text_writer_pkg::ADDR_W,
  parameter logic [7:0]  FILL_CHAR = vga_text_writer_pkg::FILL_CHAR
) (
  input logic              clk,
  input logic              rstn,
  vga_text_writer_if.slave bus
);
  import vga_text_writer_pkg::*;

  localparam int unsigned        CELLS     = ROWS * COLS;
  localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(CELLS - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_HEX   = 3'd1;
  localparam logic [2:0] ST_CHAR  = 3'd2;
  localparam logic [2:0] ST_CLEAR = 3'd3;
  localparam logic [2:0] ST_DROP  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;    // writes still to issue after the current one
  logic [31:0]       shift_q, shift_d;
  logic [7:0]        data_q, data_d;
  logic              ready_q, ready_d;
  logic              wen_q, wen_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              accept;
  logic [3:0]        ndig;
  logic [31:0]       aligned;
  logic              bad_pos;
  logic [ADDR_W-1:0] start_addr;
  logic [3:0]        nibble;
  logic [7:0]        nib_ascii;

  assign accept     = bus.req_valid & ready_q;
  assign ndig       = (bus.req_ndigits == 3'd0) ? 4'd8 : {1'b0, bus.req_ndigits};
  // Left-justify the printed digits so the next digit is always in [31:28].
  assign aligned    = bus.req_value << {4'd8 - ndig, 2'b00};
  assign bad_pos    = (32'(bus.req_row) >= ROWS) || (32'(bus.req_col) >= COLS);
  assign start_addr = ADDR_W'(bus.req_row) * ADDR_W'(COLS) + ADDR_W'(bus.req_col);
  assign nibble     = (state_q == ST_IDLE) ? aligned[31:28] : shift_q[31:28];

  hex_to_ascii u_hex_to_ascii (
    .nibble (nibble),
    .ascii  (nib_ascii)
  );

  // Command acceptance and per-cycle write sequencing.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    ready_d = ready_q;
    wen_d   = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          ready_d = 1'b0;
          state_d = ST_DROP;
          done_d  = 1'b1;
          err_d   = 1'b1;
          case (bus.req_cmd)
            CMD_CLEAR: begin
              state_d = ST_CLEAR;
              done_d  = 1'b0;
              err_d   = 1'b0;
              wen_d   = 1'b1;
              addr_d  = '0;
              data_d  = FILL_CHAR;
              cnt_d   = LAST_ADDR;
            end
            CMD_HEX: begin
              if (!bad_pos) begin
                state_d = ST_HEX;
                err_d   = 1'b0;
                done_d  = (ndig == 4'd1);
                wen_d   = 1'b1;
                addr_d  = start_addr;
                data_d  = nib_ascii;
                shift_d = aligned << 4;
                cnt_d   = ADDR_W'(ndig - 4'd1);
              end
            end
            CMD_CHAR: begin
              if (!bad_pos) begin
                state_d = ST_CHAR;
                err_d   = 1'b0;
                wen_d   = 1'b1;
                addr_d  = start_addr;
                data_d  = bus.req_value[7:0];
                cnt_d   = '0;
              end
            end
            default: ;
          endcase
        end
      end
      ST_HEX, ST_CHAR, ST_CLEAR: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
        end else begin
          wen_d   = 1'b1;
          // Column/row advance collapses to +1 on the linear address, wrapping after the last cell.
          addr_d  = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
          cnt_d   = cnt_q - ADDR_W'(1);
          done_d  = (cnt_q == ADDR_W'(1));
          data_d  = (state_q == ST_HEX) ? nib_ascii : FILL_CHAR;
          shift_d = shift_q << 4;
        end
      end
      ST_DROP: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  // State and registered outputs; reset aborts any command in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      ready_q <= 1'b1;
      wen_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      wen_q   <= wen_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.wen       = wen_q;
  assign bus.w_addr    = addr_q;
  assign bus.w_data    = data_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_vga_text_writer.sv
// Randomized scoreboard bench for vga_text_writer.
module tb_vga_text_writer;

  localparam int NCOLS  = 80;
  localparam int NROWS  = 30;
  localparam int NCELLS = NCOLS * NROWS;

  typedef struct {
    logic       wen;
    int         addr;
    logic [7:0] data;
    logic       done;
    logic       err;
  } exp_t;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;
  exp_t sb_q[$];

  vga_text_writer_if bus_if ();

  vga_text_writer dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] hex_char(input int nib);
    if (nib < 10) return 8'(48 + nib);
    return 8'(65 + nib - 10);
  endfunction

  function automatic logic is_drop(input int cmd, input int row, input int col);
    if (cmd == 3) return 1'b1;
    if (cmd == 2) return 1'b0;
    return (row >= NROWS) || (col >= NCOLS);
  endfunction

  // Reference model: list of output events a command must produce.
  task automatic model_push(input int cmd, input int row, input int col,
                            input logic [31:0] value, input int nd);
    exp_t e;
    int   n;
    int   base;
    base = row * NCOLS + col;
    if (is_drop(cmd, row, col)) begin
      e = '{wen: 1'b0, addr: 0, data: 8'h00, done: 1'b1, err: 1'b1};
      sb_q.push_back(e);
    end else if (cmd == 1) begin
      e = '{wen: 1'b1, addr: base, data: value[7:0], done: 1'b1, err: 1'b0};
      sb_q.push_back(e);
    end else if (cmd == 2) begin
      for (int a = 0; a < NCELLS; a++) begin
        e = '{wen: 1'b1, addr: a, data: 8'h20, done: (a == NCELLS - 1), err: 1'b0};
        sb_q.push_back(e);
      end
    end else begin
      n = (nd == 0) ? 8 : nd;
      for (int i = 0; i < n; i++) begin
        e.wen  = 1'b1;
        e.addr = (base + i) % NCELLS;
        e.data = hex_char(int'((value >> (4 * (n - 1 - i))) & 32'hF));
        e.done = (i == n - 1);
        e.err  = 1'b0;
        sb_q.push_back(e);
      end
    end
  endtask

  function automatic int model_busy(input int cmd, input int row, input int col, input int nd);
    if (is_drop(cmd, row, col)) return 1;
    if (cmd == 1) return 1;
    if (cmd == 2) return NCELLS;
    return (nd == 0) ? 8 : nd;
  endfunction

  // Monitor: every write or completion pulse must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus_if.wen || bus_if.done || bus_if.err) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: wen=%0b addr=%0d data=%0h done=%0b err=%0b, expected none",
                   bus_if.wen, bus_if.w_addr, bus_if.w_data, bus_if.done, bus_if.err);
        end else begin
          e = sb_q.pop_front();
          checks++;
          if (bus_if.wen !== e.wen || bus_if.done !== e.done || bus_if.err !== e.err ||
              (e.wen && (int'(bus_if.w_addr) != e.addr || bus_if.w_data !== e.data))) begin
            errors++;
            $display("FAIL write: got wen=%0b addr=%0d data=%0h done=%0b err=%0b, expected wen=%0b addr=%0d data=%0h done=%0b err=%0b at %0t",
                     bus_if.wen, bus_if.w_addr, bus_if.w_data, bus_if.done, bus_if.err,
                     e.wen, e.addr, e.data, e.done, e.err, $time);
          end
        end
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"}, longint'(bus_if.req_ready), 1);
    chk({tag, "_wen"},   longint'(bus_if.wen), 0);
    chk({tag, "_addr"},  longint'(bus_if.w_addr), 0);
    chk({tag, "_data"},  longint'(bus_if.w_data), 0);
    chk({tag, "_done"},  longint'(bus_if.done), 0);
    chk({tag, "_err"},   longint'(bus_if.err), 0);
  endtask

  // Issue one command at a negedge; returns at the negedge where ready is back, valid still high.
  task automatic send(input int cmd, input int row, input int col,
                      input logic [31:0] value, input int nd);
    int waitc;
    int busy;
    bus_if.req_cmd     = 2'(cmd);
    bus_if.req_row     = 5'(row);
    bus_if.req_col     = 7'(col);
    bus_if.req_value   = value;
    bus_if.req_ndigits = 3'(nd);
    bus_if.req_valid   = 1'b1;
    waitc = 0;
    while (!bus_if.req_ready && waitc < 3000) begin
      @(negedge clk);
      waitc++;
    end
    if (!bus_if.req_ready) begin
      chk("accept_timeout", 0, 1);
      return;
    end
    model_push(cmd, row, col, value, nd);
    @(posedge clk);
    @(negedge clk);
    busy = 0;
    while (!bus_if.req_ready && busy < 3000) begin
      busy++;
      @(negedge clk);
    end
    chk("busy_cycles", busy, model_busy(cmd, row, col, nd));
  endtask

  task automatic idle();
    bus_if.req_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_pending"}, sb_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int cmd;
    int row;
    int col;
    int nd;
    logic [31:0] val;
    bit cleared;
    checks = 0;
    errors = 0;
    cleared = 0;
    bus_if.req_valid   = 1'b0;
    bus_if.req_cmd     = 2'd0;
    bus_if.req_row     = 5'd0;
    bus_if.req_col     = 7'd0;
    bus_if.req_value   = 32'd0;
    bus_if.req_ndigits = 3'd0;
    rstn = 1'b0;
    #22;
    check_reset_vals("reset");
    rstn = 1'b1;
    @(negedge clk);

    // Directed cases.
    send(0, 2, 5, 32'hDEAD_BEEF, 0);
    send(0, 29, 78, 32'h0000_01A3, 3);
    send(1, 0, 79, 32'h0000_0041, 0);
    send(2, 31, 127, 32'h0, 0);          // bad row/col ignored; valid stays high throughout
    send(0, 30, 0, 32'h1234, 4);         // row out of range
    send(3, 1, 1, 32'h1234, 4);          // reserved command
    send(1, 3, 80, 32'h0000_0042, 0);    // col out of range
    idle();
    drain("directed");

    // Reset in the middle of an 8-digit HEX print.
    bus_if.req_cmd     = 2'd0;
    bus_if.req_row     = 5'd1;
    bus_if.req_col     = 7'd10;
    bus_if.req_value   = 32'h8765_4321;
    bus_if.req_ndigits = 3'd0;
    bus_if.req_valid   = 1'b1;
    model_push(0, 1, 10, 32'h8765_4321, 0);
    @(posedge clk);
    #1 bus_if.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rstn = 1'b0;
    while (sb_q.size() > 0) void'(sb_q.pop_back());
    #1;
    chk("abort_wen", longint'(bus_if.wen), 0);
    repeat (2) @(negedge clk);
    check_reset_vals("abort");
    #2 rstn = 1'b1;
    @(negedge clk);
    send(1, 12, 40, 32'h0000_005A, 0);
    idle();
    drain("abort");

    // Randomized traffic.
    for (int k = 0; k < 60; k++) begin
      r   = int'($urandom_range(0, 99));
      row = int'($urandom_range(0, NROWS - 1));
      col = int'($urandom_range(0, NCOLS - 1));
      val = $urandom;
      nd  = int'($urandom_range(0, 7));
      if (r < 45) cmd = 0;
      else if (r < 80) cmd = 1;
      else if (r < 92) begin
        cmd = int'($urandom_range(0, 1));
        row = int'($urandom_range(0, 31));
        col = int'($urandom_range(0, 127));
      end else if (r < 97 || cleared) cmd = 3;
      else begin
        cmd = 2;
        cleared = 1;
      end
      send(cmd, row, col, val, nd);
      if ($urandom_range(0, 3) == 0) begin
        idle();
        repeat (int'($urandom_range(1, 3))) @(negedge clk);
      end
    end
    idle();
    drain("random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
